// File: rtl/ula_pkg.sv
`timescale 1ns/1ps
// Shared opcode map and flag-register layout for the pipelined CLA ULA.
package ula_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_ADC = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    // The upper opcode bit splits the map into logic (0) and arithmetic (1) halves.
    function automatic logic op_aritmetica(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/cla_4bits.sv
`timescale 1ns/1ps
// 4-bit carry-lookahead group: sum, group propagate/generate and carry out.
module cla_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       p,
    output logic       g,
    output logic       cout
);

    logic [3:0] p_bit;
    logic [3:0] g_bit;
    logic [3:0] c;

    assign p_bit = a ^ b;
    assign g_bit = a & b;

    assign c[0] = cin;
    assign c[1] = g_bit[0] | (p_bit[0] & cin);
    assign c[2] = g_bit[1] | (p_bit[1] & g_bit[0]) | (p_bit[1] & p_bit[0] & cin);
    assign c[3] = g_bit[2] | (p_bit[2] & g_bit[1]) | (p_bit[2] & p_bit[1] & g_bit[0])
                | (p_bit[2] & p_bit[1] & p_bit[0] & cin);

    assign p    = &p_bit;
    assign g    = g_bit[3] | (p_bit[3] & g_bit[2]) | (p_bit[3] & p_bit[2] & g_bit[1])
                | (p_bit[3] & p_bit[2] & p_bit[1] & g_bit[0]);
    assign cout = g | (p & cin);
    assign s    = p_bit ^ c;

endmodule

// File: rtl/ula_cla_pipe.sv
`timescale 1ns/1ps
// Two-stage valid/ready ULA built from chained 4-bit CLA groups, with a
// registered flag set and a stored carry for multi-word add-with-carry.
module ula_cla_pipe
    import ula_pkg::*;
#(
    parameter int LARGURA = 8,
    parameter int GRUPO   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               entrada_valida,
    output logic               entrada_pronta,
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    input  logic [2:0]         seletor,
    input  logic               carry_in,
    output logic               saida_valida,
    input  logic               saida_pronta,
    output logic [LARGURA-1:0] resultado,
    output logic               carry_out,
    output logic               propagado,
    output logic               gerado,
    output logic               zero,
    output logic               negativo,
    output logic               overflow
);

    localparam int N_GRUPOS = LARGURA / GRUPO;
    localparam int MSB      = LARGURA - 1;

    if (GRUPO != 4 || LARGURA < 4 || (LARGURA % 4) != 0) begin : g_param_check
        $error("ula_cla_pipe: LARGURA must be a multiple of 4 and >= 4, GRUPO must be 4");
    end

    logic               s1_valid;
    logic [MSB:0]       s1_a;
    logic [MSB:0]       s1_b;
    logic [2:0]         s1_sel;
    logic               s1_cin;

    logic               s2_valid;
    logic               flag_c;
    logic [NUM_FLAGS-1:0] flags_q;

    logic               s2_avanca;
    logic               s1_avanca;

    assign s2_avanca      = !s2_valid || saida_pronta;
    assign s1_avanca      = !s1_valid || s2_avanca;
    assign entrada_pronta = rst_n && s1_avanca;
    assign saida_valida   = s2_valid;

    // Operand conditioning for the adder chain.
    logic [MSB:0]        op_b_ef;
    logic                cin_ef;
    logic [MSB:0]        soma;
    logic [N_GRUPOS:0]   carry;
    logic [N_GRUPOS-1:0] grp_p;
    logic [N_GRUPOS-1:0] grp_g;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        op_b_ef = s1_b;
        cin_ef  = s1_cin;
        case (s1_sel)
            OP_SUB: begin
                op_b_ef = ~s1_b;
                cin_ef  = 1'b1;
            end
            OP_ADC:  cin_ef = flag_c;
            OP_INC: begin
                op_b_ef = '0;
                cin_ef  = 1'b1;
            end
            default: ;
        endcase
    end

    assign carry[0] = cin_ef;

    for (genvar gi = 0; gi < N_GRUPOS; gi++) begin : g_grupo
        cla_4bits u_cla (
            .a    (s1_a[gi*4 +: 4]),
            .b    (op_b_ef[gi*4 +: 4]),
            .cin  (carry[gi]),
            .s    (soma[gi*4 +: 4]),
            .p    (grp_p[gi]),
            .g    (grp_g[gi]),
            .cout (carry[gi+1])
        );
    end

    logic [MSB:0]         res_n;
    logic [NUM_FLAGS-1:0] flags_n;
    logic                 p_n;
    logic                 g_n;
    logic                 g_total;

    always_comb begin
        // NOTE: g_total is a blocking accumulator; each iteration must see the previous value.
        g_total = 1'b0;
        for (int k = 0; k < N_GRUPOS; k++) begin
            g_total = grp_g[k] | (grp_p[k] & g_total);
        end

        res_n   = '0;
        flags_n = '0;
        p_n     = 1'b0;
        g_n     = 1'b0;

        if (op_aritmetica(s1_sel)) begin
            res_n           = soma;
            flags_n[FLAG_C] = carry[N_GRUPOS];
            flags_n[FLAG_V] = (s1_a[MSB] == op_b_ef[MSB]) && (soma[MSB] != s1_a[MSB]);
            p_n             = &grp_p;
            g_n             = g_total;
        end else begin
            case (s1_sel)
                OP_AND:  res_n = s1_a & s1_b;
                OP_OR:   res_n = s1_a | s1_b;
                OP_XOR:  res_n = s1_a ^ s1_b;
                default: res_n = ~s1_a;
            endcase
        end

        flags_n[FLAG_Z] = (res_n == '0);
        flags_n[FLAG_N] = res_n[MSB];
    end

    // Stage 1 payload carries no reset: it is only consumed when s1_valid is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_avanca) begin
            s1_valid <= entrada_valida;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (s1_avanca && entrada_valida) begin
            s1_a   <= A;
            s1_b   <= B;
            s1_sel <= seletor;
            s1_cin <= carry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            resultado <= '0;
            flags_q   <= '0;
            propagado <= 1'b0;
            gerado    <= 1'b0;
            flag_c    <= 1'b0;
        end else if (s2_avanca) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                resultado <= res_n;
                flags_q   <= flags_n;
                propagado <= p_n;
                gerado    <= g_n;
                // Logic ops leave the stored carry alone so ADC chains survive them.
                if (op_aritmetica(s1_sel)) begin
                    flag_c <= flags_n[FLAG_C];
                end
            end
        end
    end

    assign carry_out = flags_q[FLAG_C];
    assign zero      = flags_q[FLAG_Z];
    assign negativo  = flags_q[FLAG_N];
    assign overflow  = flags_q[FLAG_V];

endmodule

// File: tb/tb_ula_cla_pipe.sv
`timescale 1ns/1ps
// Directed self-checking bench for ula_cla_pipe at LARGURA=4 and LARGURA=8.
module tb_ula_cla_pipe;
    import ula_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 4-bit instance
    logic       v4 = 1'b0, sp4 = 1'b1, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [2:0] sel4 = '0;
    logic       ep4, sv4, co4, p4, g4, z4, n4, ov4;
    logic [3:0] r4;
    logic [9:0] obs4;

    // 8-bit instance
    logic       v8 = 1'b0, sp8 = 1'b1, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [2:0] sel8 = '0;
    logic       ep8, sv8, co8, p8, g8, z8, n8, ov8;
    logic [7:0] r8;
    logic [13:0] obs8;

    // Observed word layout: {resultado, carry_out, propagado, gerado, zero, negativo, overflow}
    assign obs4 = {r4, co4, p4, g4, z4, n4, ov4};
    assign obs8 = {r8, co8, p8, g8, z8, n8, ov8};

    ula_cla_pipe #(.LARGURA(4), .GRUPO(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .entrada_valida(v4), .entrada_pronta(ep4),
        .A(a4), .B(b4), .seletor(sel4), .carry_in(cin4),
        .saida_valida(sv4), .saida_pronta(sp4),
        .resultado(r4), .carry_out(co4), .propagado(p4), .gerado(g4),
        .zero(z4), .negativo(n4), .overflow(ov4)
    );

    ula_cla_pipe #(.LARGURA(8), .GRUPO(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .entrada_valida(v8), .entrada_pronta(ep8),
        .A(a8), .B(b8), .seletor(sel8), .carry_in(cin8),
        .saida_valida(sv8), .saida_pronta(sp8),
        .resultado(r8), .carry_out(co8), .propagado(p8), .gerado(g8),
        .zero(z8), .negativo(n8), .overflow(ov8)
    );

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] s;
        logic       c;
        logic [9:0] e;
    } vec4_t;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] s;
        logic       c;
        logic [13:0] e;
    } vec8_t;

    // One beat with no backpressure; reports saida_valida one and two cycles after the handshake.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                          input logic c, output logic v_early, output logic v_late);
        @(negedge clk);
        a4 = a; b4 = b; sel4 = s; cin4 = c; v4 = 1'b1; sp4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        v_early = sv4;
        @(negedge clk);
        v_late = sv4;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                          input logic c, output logic v_early, output logic v_late);
        @(negedge clk);
        a8 = a; b8 = b; sel8 = s; cin8 = c; v8 = 1'b1; sp8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        v_early = sv8;
        @(negedge clk);
        v_late = sv8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({sv4, obs4, sv8, obs8} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b / %b required all zero", {sv4, obs4}, {sv8, obs8});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({ep4, ep8, sv4, sv8} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_release: got ep4,ep8,sv4,sv8=%b required 1100", {ep4, ep8, sv4, sv8});
        end
    endtask

    task automatic test_arith4();
        vec4_t tab [6] = '{
            '{"add 5+7 cin0",  4'd5,  4'd7, OP_ADD, 1'b0, {4'hC, 6'b000011}},
            '{"add 5+7 cin1",  4'd5,  4'd7, OP_ADD, 1'b1, {4'hD, 6'b000011}},
            '{"add 8+7 cin1",  4'd8,  4'd7, OP_ADD, 1'b1, {4'h0, 6'b110100}},
            '{"add 10+10",     4'd10, 4'd10, OP_ADD, 1'b0, {4'h4, 6'b101001}},
            '{"sub 6-7",       4'd6,  4'd7, OP_SUB, 1'b0, {4'hF, 6'b000010}},
            '{"inc 7",         4'd7,  4'd5, OP_INC, 1'b0, {4'h8, 6'b000011}}
        };
        logic ve, vl;
        for (int i = 0; i < 6; i++) begin
            issue4(tab[i].a, tab[i].b, tab[i].s, tab[i].c, ve, vl);
            tests++;
            if ({ve, vl} !== 2'b01) begin
                fails++;
                $display("FAIL %s latency: got valid@1,@2=%b required 01", tab[i].name, {ve, vl});
            end
            tests++;
            if (obs4 !== tab[i].e) begin
                fails++;
                $display("FAIL %s: got res=%h flags=%b required res=%h flags=%b",
                         tab[i].name, obs4[9:6], obs4[5:0], tab[i].e[9:6], tab[i].e[5:0]);
            end
        end
    endtask

    task automatic test_logic4();
        vec4_t tab [4] = '{
            '{"and c&a",  4'hC, 4'hA, OP_AND, 1'b1, {4'h8, 6'b000010}},
            '{"or 0|0",   4'h0, 4'h0, OP_OR,  1'b1, {4'h0, 6'b000100}},
            '{"xor 6^3",  4'h6, 4'h3, OP_XOR, 1'b1, {4'h5, 6'b000000}},
            '{"not 5",    4'h5, 4'hF, OP_NOT, 1'b1, {4'hA, 6'b000010}}
        };
        logic ve, vl;
        for (int i = 0; i < 4; i++) begin
            issue4(tab[i].a, tab[i].b, tab[i].s, tab[i].c, ve, vl);
            tests++;
            if (vl !== 1'b1 || obs4 !== tab[i].e) begin
                fails++;
                $display("FAIL %s: got valid=%b res=%h flags=%b required valid=1 res=%h flags=%b",
                         tab[i].name, vl, obs4[9:6], obs4[5:0], tab[i].e[9:6], tab[i].e[5:0]);
            end
        end
    endtask

    task automatic test_adc_chain();
        vec8_t tab [4] = '{
            '{"add ff+01",       8'hFF, 8'h01, OP_ADD, 1'b0, {8'h00, 6'b101100}},
            '{"xor keeps carry", 8'h0F, 8'hF0, OP_XOR, 1'b0, {8'hFF, 6'b000010}},
            '{"adc 00+00 c=1",   8'h00, 8'h00, OP_ADC, 1'b0, {8'h01, 6'b000000}},
            '{"adc 00+00 c=0",   8'h00, 8'h00, OP_ADC, 1'b1, {8'h00, 6'b000100}}
        };
        logic ve, vl;
        for (int i = 0; i < 4; i++) begin
            issue8(tab[i].a, tab[i].b, tab[i].s, tab[i].c, ve, vl);
            tests++;
            if (vl !== 1'b1 || obs8 !== tab[i].e) begin
                fails++;
                $display("FAIL %s: got valid=%b res=%h flags=%b required valid=1 res=%h flags=%b",
                         tab[i].name, vl, obs8[13:6], obs8[5:0], tab[i].e[13:6], tab[i].e[5:0]);
            end
        end
    endtask

    // Four beats on consecutive cycles; results must appear on consecutive cycles, 2 cycles later.
    task automatic test_back_to_back();
        logic [7:0] ta [4] = '{8'h80, 8'h10, 8'h07, 8'h01};
        logic [7:0] tb [4] = '{8'h80, 8'h20, 8'h05, 8'h01};
        logic [2:0] ts [4] = '{OP_ADD, OP_ADC, OP_SUB, OP_ADC};
        logic [7:0] te [4] = '{8'h00, 8'h31, 8'h02, 8'h03};
        logic [7:0] got [$];
        int         when [$];
        sp8 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 4) begin
                v8 = 1'b1; a8 = ta[c]; b8 = tb[c]; sel8 = ts[c]; cin8 = 1'b0;
            end else begin
                v8 = 1'b0;
            end
            if (sv8) begin
                got.push_back(r8);
                when.push_back(c);
            end
        end
        tests++;
        if (got.size() != 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d results required 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== te[i] || when[i] != i + 2) begin
                fails++;
                $display("FAIL b2b_beat%0d: got %h at cycle %0d required %h at cycle %0d",
                         i, got[i], when[i], te[i], i + 2);
            end
        end
    endtask

    // Consumer stalls for the first 5 cycles; S1 and S2 fill and the input side must close.
    task automatic test_backpressure();
        logic [7:0] got [$];
        int         k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            sp8 = (c >= 5);
            if (k < 4) begin
                v8 = 1'b1; a8 = 8'(k + 1); b8 = 8'h10; sel8 = OP_ADD; cin8 = 1'b0;
            end else begin
                v8 = 1'b0;
            end
            #1;
            if (c == 2) begin
                tests++;
                if (ep8 !== 1'b0 || k != 2) begin
                    fails++;
                    $display("FAIL bp_ready_drop: got entrada_pronta=%b accepted=%0d required 0 and 2", ep8, k);
                end
            end
            if (c >= 2 && c <= 4) begin
                tests++;
                if (sv8 !== 1'b1 || r8 !== 8'h11) begin
                    fails++;
                    $display("FAIL bp_hold_c%0d: got valid=%b res=%h required 1 and 11", c, sv8, r8);
                end
            end
            if (sv8 && sp8) got.push_back(r8);
            if (v8 && ep8) k++;
        end
        sp8 = 1'b1;
        v8  = 1'b0;
        tests++;
        if (got.size() != 4) begin
            fails++;
            $display("FAIL bp_count: got %0d results required 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 8'(8'h11 + i)) begin
                fails++;
                $display("FAIL bp_order%0d: got %h required %h", i, got[i], 8'(8'h11 + i));
            end
        end
    endtask

    // Reset with two carry-producing beats in flight; stored carry must be discarded too.
    task automatic test_reset_midstream();
        logic ve, vl;
        @(negedge clk);
        sp8 = 1'b1; v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sel8 = OP_ADD; cin8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        v8 = 1'b0;
        tests++;
        if (sv8 !== 1'b1 || co8 !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: got valid=%b carry=%b required 1 and 1", sv8, co8);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({sv8, obs8} !== 15'd0) begin
            fails++;
            $display("FAIL rst_mid_async: got %b required all zero", {sv8, obs8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue8(8'h01, 8'h01, OP_ADC, 1'b1, ve, vl);
        tests++;
        if ({ve, vl} !== 2'b01 || obs8 !== {8'h02, 6'b000000}) begin
            fails++;
            $display("FAIL rst_mid_adc: got valid=%b%b res=%h flags=%b required 01 res=02 flags=000000",
                     ve, vl, obs8[13:6], obs8[5:0]);
        end
    endtask

    initial begin
        test_reset();
        test_arith4();
        test_logic4();
        test_adc_chain();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_backpressure();
        repeat (3) @(negedge clk);
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ula_cla_pipe.md
Name: ula_cla_pipe

Overview:
- Parametrised successor of the team's 4-bit carry-lookahead ULA.
- Operand width is configurable in multiples of 4 bits, built from chained 4-bit CLA groups.
- Two-stage valid/ready pipeline with a flags register (carry, zero, negative, overflow).
- Adds an add-with-stored-carry op so wide operands can be summed across consecutive words.
- Sits between the datapath operand bus and the result/writeback bus.

Parameters:
- LARGURA, 8, operand/result width in bits; must be a multiple of 4 and ≥4. Elaboration error otherwise.
- GRUPO, 4, CLA group size; fixed at 4, exposed for documentation only.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- entrada_valida  in  1  operand beat is valid.
- entrada_pronta  out  1  block can accept an operand beat.
- A  in  LARGURA  operand A.
- B  in  LARGURA  operand B.
- seletor  in  3  operation select.
- carry_in  in  1  external carry for ADD.
- saida_valida  out  1  result beat is valid.
- saida_pronta  in  1  consumer accepts the result.
- resultado  out  LARGURA  registered result.
- carry_out  out  1  registered carry of the result beat.
- propagado  out  1  registered full-width group propagate (AND of all group P).
- gerado  out  1  registered full-width group generate.
- zero  out  1  resultado == 0.
- negativo  out  1  resultado[MSB].
- overflow  out  1  signed overflow; 0 for logic ops.

Behaviour:
- Opcode map (seletor):
  - 000 AND, 001 OR, 010 XOR, 011 NOT A.
  - 100 ADD: A+B+carry_in.
  - 101 SUB: A+~B+1, carry_in ignored; carry_out=1 means no borrow.
  - 110 ADC: A+B+flag_c.
  - 111 INC: A+1.
- Logic ops: carry_out=0, overflow=0, propagado=0, gerado=0.
- Arithmetic: LARGURA+1-bit sum, result wraps mod 2^LARGURA.
  - overflow = (opA[MSB]==opB'[MSB]) && (res[MSB]!=opA[MSB]), where opB' is the effective second operand (~B for SUB, 0 for INC).
- Stage S1 registers A, B, seletor and carry_in when entrada_valida && entrada_pronta.
- Compute is combinational from S1 registers; stage S2 registers resultado plus all flags.
- Latency: 2 clk from input handshake to saida_valida with no backpressure. Throughput 1 beat/clk.
- Handshake:
  - s2 advances when !s2_valid || saida_pronta.
  - s1 advances when !s1_valid || s2 advances.
  - entrada_pronta = that s1-advance condition.
  - Outputs hold stable while saida_valida && !saida_pronta.
  - Inputs are ignored when entrada_valida=0.
- flag_c (internal):
  - Updated with carry_out at each S1→S2 transfer of an arithmetic op; unchanged by logic ops.
  - ADC reads flag_c at the moment it is computed, i.e. the carry of the immediately preceding accepted arithmetic beat. No hazard, since that beat has already reached S2.
- Simultaneous input accept and output drain in the same cycle: both occur, no bubble.
- Reset (asynchronous, at any time including mid-stream):
  - s1_valid=0, s2_valid=0, flag_c=0.
  - All outputs 0; entrada_pronta=1 after reset release.
  - In-flight beats are discarded.
- Stall: S2 full and saida_pronta=0 → S1 fills, then entrada_pronta=0. No beat is lost or duplicated.

Decomposition:
- Package ula_pkg: opcode localparams (OP_AND … OP_INC) and flag bit indices.
- Sub-module cla_4bits: 4-bit carry-lookahead group with inputs a, b, cin and outputs s, p, g, cout.
  - Instantiated LARGURA/4 times, ripple between groups.
  - Full-width P/G formed from the group p/g.

Test Plan:
- LARGURA=4, ADD 5+7 cin=0 → resultado=12, carry_out=0, overflow=1, 2-cycle latency. Repeat with cin=1 → 13.
- LARGURA=4, ADD 8+7 cin=1 → resultado=0, carry_out=1, zero=1, propagado=1.
- LARGURA=4, ADD 10+10 cin=0 → resultado=4, carry_out=1, overflow=1, negativo=0. SUB 6-7 → resultado=15, carry_out=0, negativo=1.
- LARGURA=8, ADD 8'hFF+8'h01 cin=0 then ADC 8'h00+8'h00 → results 8'h00 (carry 1) then 8'h01. Logic op XOR between the two must not disturb flag_c.
- Backpressure: stream 4 beats back-to-back, saida_pronta=0 for 3 cycles → entrada_pronta drops after 2 beats are held. Results emerge in order, no loss or duplication.
- Assert rst_n low while 2 beats are in flight → saida_valida=0 immediately. After release, ADC 1+1 → 2 (flag_c cleared).
